pipe_stage_elastic: RTL and testbench

Parametrised pipeline stage register, the successor to the fixed MEM/WB-style latch. It carries a data bundle and a control bundle between pipeline stages using a valid/ready handshake, so downstream stalls no longer need global enables. It supports a synchronous flush that injects a bubble with zeroed control bits. An optional 2-entry skid buffer breaks the combinational ready path. It is used for every inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_elastic_pkg.sv | 19 +
 rtl/pipe_stage_elastic_entry.sv | 35 +++
 rtl/pipe_stage_elastic.sv | 150 +++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_elastic_pkg.sv
// Shared pipeline definitions: control bundle layout and occupancy encoding
// used by the elastic inter-stage register.
package pipe_stage_elastic_pkg;

  localparam int CTRL_W = 5;

  localparam int CTRL_JUMP   = 0;
  localparam int CTRL_BRANCH = 1;
  localparam int CTRL_PC     = 2;
  localparam int CTRL_M2R    = 3;
  localparam int CTRL_REGW   = 4;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_stage_elastic_entry.sv
// Single pipeline entry: valid flag plus data and control bundles.
// Clearing invalidates the entry and zeroes control so a bubble never
// carries stale control bits; data is left as-is.
module pipe_entry_reg #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Entry storage; clear wins over load so a flush always empties the entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d_data;
      ctrl  <= d_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register with valid/ready handshake, synchronous
// flush and an optional second (skid) entry that makes in_ready registered.
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int DATA_W = 69,
  parameter int CTRL_W = pipe_stage_elastic_pkg::CTRL_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  occ_e occ, occ_next;

  logic              accept, consume;
  logic              out_load, out_clear, out_from_skid;
  logic              skid_load, skid_clear;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [CTRL_W-1:0] out_ctrl_q;
  logic [DATA_W-1:0] out_d_data;
  logic [CTRL_W-1:0] out_d_ctrl;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  assign out_d_data = out_from_skid ? skid_data : in_data;
  assign out_d_ctrl = out_from_skid ? skid_ctrl : in_ctrl;

  pipe_entry_reg #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_out_entry (
    .clk    (clk),
    .rst    (rst),
    .load   (out_load),
    .clear  (out_clear),
    .d_data (out_d_data),
    .d_ctrl (out_d_ctrl),
    .valid  (out_valid),
    .data   (out_data),
    .ctrl   (out_ctrl_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_entry_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
      ) u_skid_entry (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .clear  (skid_clear),
        .d_data (in_data),
        .d_ctrl (in_ctrl),
        .valid  (skid_valid),
        .data   (skid_data),
        .ctrl   (skid_ctrl)
      );
      // Ready depends only on registered skid state, cutting the out_ready path.
      assign in_ready = ~skid_valid & ~rst;
    end else begin : g_noskid
      logic unused_skid;
      assign skid_valid  = 1'b0;
      assign skid_data   = '0;
      assign skid_ctrl   = '0;
      assign unused_skid = skid_load ^ skid_clear;
      // Single entry: room exists when empty or when the held beat leaves now.
      assign in_ready = (~out_valid | out_ready) & ~rst;
    end
  endgenerate

  assign out_ctrl  = out_valid ? out_ctrl_q : '0;
  assign occupancy = occ;

  // Occupancy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ <= OCC_EMPTY;
    else     occ <= occ_next;
  end

  // Next occupancy and entry load/clear steering; flush overrides handshakes.
  always_comb begin
    occ_next      = occ;
    out_load      = 1'b0;
    out_clear     = 1'b0;
    out_from_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    if (flush) begin
      out_clear  = 1'b1;
      skid_clear = 1'b1;
      occ_next   = OCC_EMPTY;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (accept) begin
            out_load = 1'b1;
            occ_next = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept && consume) begin
            out_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            occ_next  = OCC_TWO;
          end else if (consume) begin
            out_clear = 1'b1;
            occ_next  = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (consume) begin
            out_load      = 1'b1;
            out_from_skid = 1'b1;
            skid_clear    = 1'b1;
            occ_next      = OCC_ONE;
          end
        end
        default: begin
          out_clear  = 1'b1;
          skid_clear = 1'b1;
          occ_next   = OCC_EMPTY;
        end
      endcase
    end
  end

  // Occupancy must never reach an encoding the configuration cannot hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (occ != 2'd3 && (SKID != 0 || occ != OCC_TWO));
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench: SKID=1 and SKID=0 stages share stimulus and are each
// compared every cycle against a queue-based model of the stage.
module tb_pipe_stage_elastic;

  localparam int DATA_W = 69;
  localparam int CTRL_W = 5;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic              out_ready = 1'b0;

  logic              in_ready1, out_valid1, in_ready0, out_valid0;
  logic [DATA_W-1:0] out_data1, out_data0;
  logic [CTRL_W-1:0] out_ctrl1, out_ctrl0;
  logic [1:0]        occupancy1, occupancy0;

  beat_t q1[$];
  beat_t q0[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_ctrl(out_ctrl1), .occupancy(occupancy1)
  );

  pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_ctrl(out_ctrl0), .occupancy(occupancy0)
  );

  task automatic checkOne(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkDut(input string nm, input bit skid, input int sz, input beat_t head,
                          input logic ov, input logic ir, input logic [DATA_W-1:0] od,
                          input logic [CTRL_W-1:0] oc, input logic [1:0] occ);
    logic exp_ready;
    if (rst) exp_ready = 1'b0;
    else if (skid) exp_ready = (sz < 2);
    else exp_ready = (sz == 0) || out_ready;
    checkOne({nm, ".out_valid"}, 128'(ov), 128'(sz != 0));
    checkOne({nm, ".in_ready"}, 128'(ir), 128'(exp_ready));
    checkOne({nm, ".occupancy"}, 128'(occ), 128'(sz));
    checkOne({nm, ".out_ctrl"}, 128'(oc), (sz != 0) ? 128'(head.c) : 128'(0));
    if (sz != 0) checkOne({nm, ".out_data"}, 128'(od), 128'(head.d));
  endtask

  task automatic checkOutput();
    beat_t h1, h0;
    h1 = (q1.size() > 0) ? q1[0] : '0;
    h0 = (q0.size() > 0) ? q0[0] : '0;
    checkDut("skid1", 1'b1, q1.size(), h1, out_valid1, in_ready1, out_data1, out_ctrl1, occupancy1);
    checkDut("skid0", 1'b0, q0.size(), h0, out_valid0, in_ready0, out_data0, out_ctrl0, occupancy0);
  endtask

  // Reset clears every register, so data must read zero as well.
  task automatic checkReset();
    checkOutput();
    checkOne("skid1.reset_data", 128'(out_data1), 128'(0));
    checkOne("skid0.reset_data", 128'(out_data0), 128'(0));
  endtask

  task automatic modelStep();
    bit acc1, acc0, con1, con0;
    beat_t b;
    if (rst || flush) begin
      q1.delete();
      q0.delete();
      return;
    end
    b.d = in_data;
    b.c = in_ctrl;
    acc1 = in_valid && (q1.size() < 2);
    acc0 = in_valid && (q0.size() == 0 || out_ready);
    con1 = (q1.size() > 0) && out_ready;
    con0 = (q0.size() > 0) && out_ready;
    if (con1) void'(q1.pop_front());
    if (con0) void'(q0.pop_front());
    if (acc1) q1.push_back(b);
    if (acc0) q0.push_back(b);
  endtask

  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                               input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    checkOutput();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] randData();
    return {5'($urandom()), $urandom(), $urandom()};
  endfunction

  initial begin
    // Reset state while rst is held
    #2;
    checkReset();
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    $display("[TB] reset released");

    // First post-reset cycle: idle, stage empty and ready
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

    // Streaming 0x1..0x8 with ctrl 10001
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, DATA_W'(i), 5'b10001, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

    // Backpressure: A, B fill the skid stage, C waits upstream, then drain
    applyStimulus(1'b1, DATA_W'('hA), 5'b00011, 1'b0, 1'b0);
    applyStimulus(1'b1, DATA_W'('hB), 5'b00101, 1'b0, 1'b0);
    applyStimulus(1'b1, DATA_W'('hC), 5'b01001, 1'b0, 1'b0);
    applyStimulus(1'b1, DATA_W'('hC), 5'b01001, 1'b0, 1'b0);
    applyStimulus(1'b1, DATA_W'('hC), 5'b01001, 1'b1, 1'b0);
    applyStimulus(1'b1, DATA_W'('hC), 5'b01001, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush while full with a beat offered in the same cycle
    applyStimulus(1'b1, DATA_W'('h11), 5'b11111, 1'b0, 1'b0);
    applyStimulus(1'b1, DATA_W'('h12), 5'b11110, 1'b0, 1'b0);
    applyStimulus(1'b1, DATA_W'('hD), 5'b10101, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

    // Toggling out_ready with continuous input
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, DATA_W'('h20 + i), 5'(i), (i % 2) == 0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

    // Randomised traffic with occasional flushes
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 3) != 0, randData(), 5'($urandom()),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-transfer with the skid stage full
    applyStimulus(1'b1, DATA_W'('h31), 5'b00111, 1'b0, 1'b0);
    applyStimulus(1'b1, DATA_W'('h32), 5'b01111, 1'b0, 1'b0);
    #2;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    q1.delete();
    q0.delete();
    checkReset();
    @(posedge clk);
    #2;
    checkReset();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, DATA_W'('h5A), 5'b10001, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
